button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Input-side counterpart of the score/7-segment output path.
- Conditions raw board push-buttons into clean, clock-synchronous game events: the `jump` pulse consumed by the score counter and the game FSM, plus other control buttons.
- Each channel does three things in order: 2-flop synchronisation, debounce, then edge and auto-repeat generation.
- Sits between the top-level button pins and the game logic, running on the 100 MHz system clock.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must hold a new level before it is accepted (10 ms). Must be >= 1.
- HOLD_CYCLES, 50000000, cycles a press must be held before the first auto-repeat (0.5 s). Must be >= 1.
- REPEAT_CYCLES, 10000000, auto-repeat period once repeating (100 ms). Must be >= 1.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  N_BTN  raw button pins, asynchronous, active-high.
- btn_level  output  N_BTN  debounced button level.
- btn_press  output  N_BTN  one-cycle pulse when a debounced 0->1 change is accepted.
- btn_release  output  N_BTN  one-cycle pulse when a debounced 1->0 change is accepted.
- btn_repeat  output  N_BTN  one-cycle auto-repeat pulse while the button is held.
- btn_act  output  N_BTN  btn_press OR btn_repeat; drives `jump`.

Behaviour:
- Reset (asynchronous, active-high):
  - All sync flops, stable levels, counters and outputs go to 0.
  - Every channel FSM goes to RELEASED.
  - Reset mid-operation aborts any debounce or hold count; no pulses are emitted during reset.
- Synchroniser: 2 flops per channel. sync[i] follows btn_raw[i] with 2-cycle latency.
- Debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - When sync == stable, the counter clears to 0.
  - When sync != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and sync still != stable, then at the next edge: stable <= sync and the counter clears.
  - Total latency from a btn_raw edge to a btn_level change is 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES sync cycles produces no level change.
- Edge pulses:
  - btn_press and btn_release are registered.
  - They assert in the same cycle btn_level first shows the new value, for exactly 1 cycle.
- Hold/repeat FSM, per channel, with counter width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1):
  - RELEASED: counter = 0. On an accepted press -> PRESSED, counter = 0.
  - PRESSED: counter increments each cycle. At counter == HOLD_CYCLES-1, emit btn_repeat next cycle -> REPEATING, counter = 0. So the first repeat comes HOLD_CYCLES cycles after btn_press.
  - REPEATING: counter increments. At counter == REPEAT_CYCLES-1, emit btn_repeat next cycle and clear the counter. Repeats are therefore REPEAT_CYCLES apart.
  - From PRESSED or REPEATING, an accepted release -> RELEASED with the counter cleared.
- Simultaneous events:
  - Release accepted in the same cycle a repeat would fire: release wins and no btn_repeat is emitted.
  - btn_press and btn_repeat are never high together.
- btn_act: the registered OR of btn_press and btn_repeat. It has the same timing as those pulses, so it needs no extra cycle.
- Channels are fully independent; simultaneous presses on several channels produce simultaneous pulses.
- Button held through reset deassertion: stable restarts at 0, so btn_press is produced 2 + DEBOUNCE_CYCLES cycles after reset falls.

Decomposition:
- Shared package holds:
  - the default timing constants: CLK_HZ = 100000000, DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES;
  - the channel FSM state encoding: RELEASED = 2'b00, PRESSED = 2'b01, REPEATING = 2'b10.
- One sub-module, button_channel: a single-bit synchroniser, debouncer and hold/repeat FSM.
- button_conditioner instantiates N_BTN copies in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, N_BTN=4):
- Clean press: btn_raw[0] 0->1 before edge 0 and held -> btn_level[0] = 1 and btn_press[0] = btn_act[0] = 1 for one cycle at edge 6; other channels stay 0.
- Glitches: 3-cycle high pulse on btn_raw[1], then a bounce pattern 1,0,1,1,0,1,1,1,1 -> no pulse from the 3-cycle glitch; exactly one btn_press[1], 6 cycles after the final rise.
- Auto-repeat: hold btn_raw[2] for 30 cycles after press -> btn_repeat[2] at press+10, +13, +16, +19, ...; btn_act mirrors these; btn_release[2] 6 cycles after btn_raw falls.
- Release vs repeat collision: release accepted on the exact cycle a repeat is due -> btn_release = 1, btn_repeat = 0, FSM returns to RELEASED.
- Reset mid-hold: assert reset while REPEATING with the button still held -> all outputs 0 immediately; after reset deasserts, btn_press is re-emitted at reset-fall+6.
- Simultaneous: all 4 buttons pressed on the same cycle -> btn_press = 4'b1111 for one cycle.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
//------------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared definitions for the push-button input conditioner:
//     - default timing constants for a 100 MHz system clock
//     - per-channel hold/repeat FSM state encoding
//     - a small elaboration-time helper for sizing counters
//------------------------------------------------------------------------------
package button_conditioner_pkg;

   // System clock frequency the defaults below are derived from.
   localparam int CLK_HZ          = 100000000;

   // 10 ms debounce window at 100 MHz.
   localparam int DEBOUNCE_CYCLES = 1000000;

   // 0.5 s before the first auto-repeat at 100 MHz.
   localparam int HOLD_CYCLES     = 50000000;

   // 100 ms between auto-repeats at 100 MHz.
   localparam int REPEAT_CYCLES   = 10000000;

   // Per-channel hold/repeat state.
   typedef enum logic [1:0] {
      RELEASED  = 2'b00,
      PRESSED   = 2'b01,
      REPEATING = 2'b10
   } chan_state_t;

   // Larger of two integers; used to size the shared hold/repeat counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : button_conditioner_pkg

// File: rtl/button_conditioner_if.sv
//------------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the raw button pins and the conditioned event outputs.
//
//   Signals (all N_BTN wide, one bit per channel):
//     btn_raw      raw, asynchronous, active-high button pins
//     btn_level    debounced button level
//     btn_press    one-cycle pulse on an accepted 0->1 change
//     btn_release  one-cycle pulse on an accepted 1->0 change
//     btn_repeat   one-cycle auto-repeat pulse while held
//     btn_act      btn_press | btn_repeat (drives the game's jump input)
//
//   Modports:
//     master  board/pin side: drives btn_raw, consumes the events
//     slave   the conditioner: samples btn_raw, produces the events
//------------------------------------------------------------------------------
interface button_conditioner_if #(
   parameter int N_BTN = 4
);

   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_repeat;
   logic [N_BTN-1:0] btn_act;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_repeat,
      input  btn_act
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_repeat,
      output btn_act
   );

endinterface : button_conditioner_if

// File: rtl/button_conditioner_channel.sv
//------------------------------------------------------------------------------
// button_channel
//   One push-button channel: 2-flop synchroniser, debouncer, edge detector
//   and hold/repeat FSM. All outputs are registered.
//
//   Ports:
//     clk          system clock
//     reset        asynchronous, active-high reset
//     btn_raw      raw button pin (asynchronous)
//     btn_level    debounced level
//     btn_press    one-cycle pulse when a debounced rise is accepted
//     btn_release  one-cycle pulse when a debounced fall is accepted
//     btn_repeat   one-cycle auto-repeat pulse while held
//     btn_act      btn_press | btn_repeat, same timing as those pulses
//
//   Timing (raw edge just before clock edge 0):
//     edge 1            sync_2_reg shows the new value
//     edge 1+DEBOUNCE   stable_reg takes the new value
//     edge 2+DEBOUNCE   btn_level and the press/release pulse appear together
//------------------------------------------------------------------------------
module button_channel #(
   parameter int DEBOUNCE_CYCLES = button_conditioner_pkg::DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = button_conditioner_pkg::HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = button_conditioner_pkg::REPEAT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat,
   output logic btn_act
);

   import button_conditioner_pkg::*;

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HR_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYCLES - 1);
   localparam logic [HR_W-1:0] REP_LAST  = HR_W'(REPEAT_CYCLES - 1);

   // Synchroniser and debouncer state
   logic            sync_1_reg;
   logic            sync_2_reg;
   logic            stable_reg;
   logic [DB_W-1:0] db_cnt_reg;

   // Edge / hold / repeat state and registered outputs
   chan_state_t     state_reg;
   logic [HR_W-1:0] hr_cnt_reg;
   logic            level_reg;
   logic            press_reg;
   logic            release_reg;
   logic            repeat_reg;
   logic            act_reg;

   // level_reg lags stable_reg by one cycle, so a difference between them
   // marks the single cycle in which a new debounced level was accepted.
   logic rise;
   logic fall;

   assign rise = stable_reg & ~level_reg;
   assign fall = ~stable_reg & level_reg;

   //---------------------------------------------------------------------------
   // Synchroniser + debouncer
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_1_reg <= 1'b0;
         sync_2_reg <= 1'b0;
         stable_reg <= 1'b0;
         db_cnt_reg <= '0;
      end else begin
         sync_1_reg <= btn_raw;
         sync_2_reg <= sync_1_reg;
         if (sync_2_reg == stable_reg) begin
            // Any return to the accepted level restarts the window, so a
            // glitch shorter than the window never gets through.
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DB_LAST) begin
            stable_reg <= sync_2_reg;
            db_cnt_reg <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Edge pulses and hold/repeat FSM (registered outputs)
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= RELEASED;
         hr_cnt_reg  <= '0;
         level_reg   <= 1'b0;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
         repeat_reg  <= 1'b0;
         act_reg     <= 1'b0;
      end else begin
         level_reg   <= stable_reg;
         press_reg   <= rise;
         release_reg <= fall;
         repeat_reg  <= 1'b0;
         act_reg     <= rise;

         case (state_reg)
            RELEASED: begin
               hr_cnt_reg <= '0;
               if (rise) begin
                  state_reg <= PRESSED;
               end
            end

            PRESSED: begin
               // A release in the same cycle as a due repeat suppresses it.
               if (fall) begin
                  state_reg  <= RELEASED;
                  hr_cnt_reg <= '0;
               end else if (hr_cnt_reg == HOLD_LAST) begin
                  state_reg  <= REPEATING;
                  hr_cnt_reg <= '0;
                  repeat_reg <= 1'b1;
                  act_reg    <= 1'b1;
               end else begin
                  hr_cnt_reg <= hr_cnt_reg + 1'b1;
               end
            end

            REPEATING: begin
               if (fall) begin
                  state_reg  <= RELEASED;
                  hr_cnt_reg <= '0;
               end else if (hr_cnt_reg == REP_LAST) begin
                  hr_cnt_reg <= '0;
                  repeat_reg <= 1'b1;
                  act_reg    <= 1'b1;
               end else begin
                  hr_cnt_reg <= hr_cnt_reg + 1'b1;
               end
            end

            default: begin
               state_reg  <= RELEASED;
               hr_cnt_reg <= '0;
            end
         endcase
      end
   end

   assign btn_level   = level_reg;
   assign btn_press   = press_reg;
   assign btn_release = release_reg;
   assign btn_repeat  = repeat_reg;
   assign btn_act     = act_reg;

endmodule : button_channel

// File: rtl/button_conditioner.sv
//------------------------------------------------------------------------------
// button_conditioner
//   Turns raw board push-buttons into clean, clock-synchronous game events.
//   N_BTN independent channels; each one synchronises, debounces and then
//   produces press/release edges and hold-to-repeat pulses.
//
//   Ports:
//     clk    system clock (100 MHz)
//     reset  asynchronous, active-high reset
//     bus    button_conditioner_if.slave: btn_raw in; btn_level, btn_press,
//            btn_release, btn_repeat, btn_act out (N_BTN bits each)
//------------------------------------------------------------------------------
module button_conditioner #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = button_conditioner_pkg::DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = button_conditioner_pkg::HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = button_conditioner_pkg::REPEAT_CYCLES
) (
   input logic                 clk,
   input logic                 reset,
   button_conditioner_if.slave bus
);

   import button_conditioner_pkg::*;

   logic [N_BTN-1:0] level_vec;
   logic [N_BTN-1:0] press_vec;
   logic [N_BTN-1:0] release_vec;
   logic [N_BTN-1:0] repeat_vec;
   logic [N_BTN-1:0] act_vec;

   genvar gi;
   generate
      for (gi = 0; gi < N_BTN; gi++) begin : g_chan
         button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
         ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (bus.btn_raw[gi]),
            .btn_level   (level_vec[gi]),
            .btn_press   (press_vec[gi]),
            .btn_release (release_vec[gi]),
            .btn_repeat  (repeat_vec[gi]),
            .btn_act     (act_vec[gi])
         );
      end
   endgenerate

   assign bus.btn_level   = level_vec;
   assign bus.btn_press   = press_vec;
   assign bus.btn_release = release_vec;
   assign bus.btn_repeat  = repeat_vec;
   assign bus.btn_act     = act_vec;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
//------------------------------------------------------------------------------
// tb_button_conditioner
//   Directed scoreboard bench for button_conditioner with
//   DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, N_BTN=4.
//   Stimulus changes btn_raw on falling edges; a raw change made while the
//   edge counter reads c first shows on btn_level at count c+7 (edge 0 is
//   count c+1, level/press appear at edge 6).
//------------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int NB = 4;

   logic clk;
   logic reset;
   int   cyc;
   int   total;
   int   bad;

   typedef struct {
      int         at;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] rep;
      logic [3:0] act;
   } exp_t;

   exp_t sb[$];

   button_conditioner_if #(.N_BTN(NB)) bus();

   button_conditioner #(
      .N_BTN           (NB),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .REPEAT_CYCLES   (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %b want %b (cyc %0d)", name, got, want, cyc);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic push(input int at, input logic [3:0] lvl, input logic [3:0] prs,
                       input logic [3:0] rel, input logic [3:0] rep, input logic [3:0] act);
      exp_t e;
      e.at  = at;
      e.lvl = lvl;
      e.prs = prs;
      e.rel = rel;
      e.rep = rep;
      e.act = act;
      sb.push_back(e);
   endtask

   task automatic at_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk4({tag, "_level"},   bus.btn_level,   4'b0000);
      chk4({tag, "_press"},   bus.btn_press,   4'b0000);
      chk4({tag, "_release"}, bus.btn_release, 4'b0000);
      chk4({tag, "_repeat"},  bus.btn_repeat,  4'b0000);
      chk4({tag, "_act"},     bus.btn_act,     4'b0000);
   endtask

   // Monitor: any pulse on any channel is one DUT event; pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && (|{bus.btn_press, bus.btn_release, bus.btn_repeat, bus.btn_act})) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: cyc %0d prs %b rel %b rep %b act %b, none expected",
                        cyc, bus.btn_press, bus.btn_release, bus.btn_repeat, bus.btn_act);
            end else begin
               e = sb.pop_front();
               $display("event cyc=%0d lvl=%b prs=%b rel=%b rep=%b act=%b", cyc,
                        bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat, bus.btn_act);
               chk_int("event_cycle", cyc, e.at);
               chk4("ev_level",   bus.btn_level,   e.lvl);
               chk4("ev_press",   bus.btn_press,   e.prs);
               chk4("ev_release", bus.btn_release, e.rel);
               chk4("ev_repeat",  bus.btn_repeat,  e.rep);
               chk4("ev_act",     bus.btn_act,     e.act);
            end
         end
      end
   end

   initial begin
      int t;
      int p;
      int b;
      logic pat [9];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      cyc   = 0;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.btn_raw = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset_state");
      reset = 1'b0;

      // Clean press on channel 0, released before the first repeat is due.
      t = cyc + 2;
      at_cyc(t);
      bus.btn_raw[0] = 1'b1;
      push(t + 7, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      at_cyc(t + 9);
      bus.btn_raw[0] = 1'b0;
      push(t + 16, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

      // Channel 1: 3-cycle glitch (ignored), then a bounce ending high.
      t = cyc + 12;
      at_cyc(t);
      bus.btn_raw[1] = 1'b1;
      at_cyc(t + 3);
      bus.btn_raw[1] = 1'b0;
      b = t + 12;
      push(b + 12, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
      for (int k = 0; k < 9; k++) begin
         at_cyc(b + k);
         bus.btn_raw[1] = pat[k];
      end
      at_cyc(b + 14);
      bus.btn_raw[1] = 1'b0;
      push(b + 21, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

      // Channel 2 auto-repeat: press P, repeats P+10, +13, ... release P+30.
      t = cyc + 12;
      at_cyc(t);
      bus.btn_raw[2] = 1'b1;
      p = t + 7;
      push(p, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
      for (int k = 0; k < 7; k++)
         push(p + 10 + 3 * k, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
      at_cyc(p + 23);
      bus.btn_raw[2] = 1'b0;
      push(p + 30, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

      // Channel 3: release lands on the first repeat slot (P+10).
      t = cyc + 12;
      at_cyc(t);
      bus.btn_raw[3] = 1'b1;
      p = t + 7;
      push(p, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
      at_cyc(p + 3);
      bus.btn_raw[3] = 1'b0;
      push(p + 10, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);

      // Channel 3 again: back in RELEASED, so a fresh hold repeats at P+10,
      // P+13, and the release collides with the P+16 repeat.
      t = cyc + 12;
      at_cyc(t);
      bus.btn_raw[3] = 1'b1;
      p = t + 7;
      push(p, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
      push(p + 10, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
      push(p + 13, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
      at_cyc(p + 9);
      bus.btn_raw[3] = 1'b0;
      push(p + 16, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);

      // Channel 2: reset while REPEATING with the button still held.
      t = cyc + 12;
      at_cyc(t);
      bus.btn_raw[2] = 1'b1;
      p = t + 7;
      push(p, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
      push(p + 10, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
      push(p + 13, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
      at_cyc(p + 14);
      reset = 1'b1;
      #1;
      chk_all_zero("reset_mid_hold");
      at_cyc(p + 17);
      chk_all_zero("reset_held");
      reset = 1'b0;
      t = cyc;
      push(t + 7, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
      at_cyc(t + 9);
      bus.btn_raw[2] = 1'b0;
      push(t + 16, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

      // All four channels pressed and released together.
      t = cyc + 12;
      at_cyc(t);
      bus.btn_raw = 4'b1111;
      push(t + 7, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
      at_cyc(t + 9);
      bus.btn_raw = 4'b0000;
      push(t + 16, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

      at_cyc(t + 30);
      chk_all_zero("idle_end");
      chk_int("missing_events", sb.size(), 0);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         $display("FAIL missing_event: expected at cyc %0d prs %b rel %b rep %b, got none",
                  e.at, e.prs, e.rel, e.rep);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_button_conditioner
